time_set_ctrl: RTL and testbench

//  Timekeeping controller for the digital clock. Owns the hour/minute/second

---
 rtl/time_set_ctrl.sv | 166 ++++++++++++++++
 tb/tb_time_set_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : time_set_ctrl
// Description : Clock timekeeping registers with RUN/SET_H/SET_M/SET_S mode
//               FSM, button stepping, blink blanking and set-mode timeout.
// Revision    : 1.0
// ============================================================================
module time_set_ctrl #(
    parameter int H_MAX     = 24,
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       blink_tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic [1:0] mode,
    output logic [2:0] blank,
    output logic       day_pulse
);

    localparam logic [1:0] c_RUN   = 2'd0;
    localparam logic [1:0] c_SET_H = 2'd1;
    localparam logic [1:0] c_SET_M = 2'd2;
    localparam logic [1:0] c_SET_S = 2'd3;

    localparam int              c_TO_W    = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'((TIMEOUT_S > 0) ? TIMEOUT_S - 1 : 0);
    localparam logic [7:0]      c_H_LAST  = 8'(H_MAX - 1);
    localparam logic [7:0]      c_MS_LAST = 8'd59;

    logic              r_btn_mode_q, r_btn_inc_q, r_btn_dec_q;
    logic [1:0]        r_mode, w_mode_nxt;
    logic              r_blink, w_blink_nxt;
    logic [c_TO_W-1:0] r_to_cnt, w_to_nxt;
    logic [7:0]        r_hour, r_min, r_sec;
    logic [7:0]        w_hour_nxt, w_min_nxt, w_sec_nxt;
    logic [2:0]        r_blank, w_blank_nxt;
    logic              r_day, w_day_nxt;
    logic              w_step;

    logic w_rise_mode, w_rise_inc, w_rise_dec;
    assign w_rise_mode = btn_mode & ~r_btn_mode_q;
    assign w_rise_inc  = btn_inc  & ~r_btn_inc_q;
    assign w_rise_dec  = btn_dec  & ~r_btn_dec_q;

    always_comb begin
        w_mode_nxt = r_mode;
        w_to_nxt   = r_to_cnt;
        w_hour_nxt = r_hour;
        w_min_nxt  = r_min;
        w_sec_nxt  = r_sec;
        w_day_nxt  = 1'b0;
        w_step     = 1'b0;

        if (r_mode == c_RUN) begin
            w_to_nxt = '0;
            if (w_rise_mode) begin
                w_mode_nxt = c_SET_H;
            end
            if (tick) begin
                if (r_sec == c_MS_LAST) begin
                    w_sec_nxt = 8'd0;
                    if (r_min == c_MS_LAST) begin
                        w_min_nxt = 8'd0;
                        if (r_hour == c_H_LAST) begin
                            w_hour_nxt = 8'd0;
                            w_day_nxt  = 1'b1;
                        end else begin
                            w_hour_nxt = r_hour + 8'd1;
                        end
                    end else begin
                        w_min_nxt = r_min + 8'd1;
                    end
                end else begin
                    w_sec_nxt = r_sec + 8'd1;
                end
            end
        end else if (w_rise_mode) begin
            // SET_S + 1 wraps to RUN; any pending step or tick is dropped
            w_mode_nxt = r_mode + 2'd1;
            w_to_nxt   = '0;
        end else if (w_rise_inc | w_rise_dec) begin
            w_to_nxt = '0;
            if (w_rise_inc ^ w_rise_dec) begin
                w_step = 1'b1;
                case (r_mode)
                    c_SET_H: begin
                        if (w_rise_inc) w_hour_nxt = (r_hour == c_H_LAST) ? 8'd0 : r_hour + 8'd1;
                        else            w_hour_nxt = (r_hour == 8'd0) ? c_H_LAST : r_hour - 8'd1;
                    end
                    c_SET_M: begin
                        if (w_rise_inc) w_min_nxt = (r_min == c_MS_LAST) ? 8'd0 : r_min + 8'd1;
                        else            w_min_nxt = (r_min == 8'd0) ? c_MS_LAST : r_min - 8'd1;
                    end
                    default: w_sec_nxt = 8'd0;
                endcase
            end
        end else if (tick && (TIMEOUT_S != 0)) begin
            if (r_to_cnt == c_TO_LAST) begin
                w_mode_nxt = c_RUN;
                w_to_nxt   = '0;
            end else begin
                w_to_nxt = r_to_cnt + c_TO_W'(1);
            end
        end

        if ((w_mode_nxt != r_mode) || w_step) begin
            w_blink_nxt = 1'b0;
        end else if (blink_tick && (r_mode != c_RUN)) begin
            w_blink_nxt = ~r_blink;
        end else begin
            w_blink_nxt = r_blink;
        end

        case (w_mode_nxt)
            c_SET_H: w_blank_nxt = {w_blink_nxt, 2'b00};
            c_SET_M: w_blank_nxt = {1'b0, w_blink_nxt, 1'b0};
            c_SET_S: w_blank_nxt = {2'b00, w_blink_nxt};
            default: w_blank_nxt = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            // Load current levels so a button held through reset gives no edge
            r_btn_mode_q <= btn_mode;
            r_btn_inc_q  <= btn_inc;
            r_btn_dec_q  <= btn_dec;
            r_mode       <= c_RUN;
            r_blink      <= 1'b0;
            r_to_cnt     <= '0;
            r_hour       <= 8'd0;
            r_min        <= 8'd0;
            r_sec        <= 8'd0;
            r_blank      <= 3'b000;
            r_day        <= 1'b0;
        end else begin
            r_btn_mode_q <= btn_mode;
            r_btn_inc_q  <= btn_inc;
            r_btn_dec_q  <= btn_dec;
            r_mode       <= w_mode_nxt;
            r_blink      <= w_blink_nxt;
            r_to_cnt     <= w_to_nxt;
            r_hour       <= w_hour_nxt;
            r_min        <= w_min_nxt;
            r_sec        <= w_sec_nxt;
            r_blank      <= w_blank_nxt;
            r_day        <= w_day_nxt;
        end
    end

    assign hour      = r_hour;
    assign min       = r_min;
    assign sec       = r_sec;
    assign mode      = r_mode;
    assign blank     = r_blank;
    assign day_pulse = r_day;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_set_ctrl
// Description : Directed and random stimulus for time_set_ctrl, checked each
//               cycle against a seconds-of-day reference model.
// Revision    : 1.0
// ============================================================================
module tb_time_set_ctrl;

    localparam int H_MAX     = 24;
    localparam int TIMEOUT_S = 30;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       tick = 1'b0;
    logic       blink_tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [7:0] hour, min, sec;
    logic [1:0] mode;
    logic [2:0] blank;
    logic       day_pulse;

    time_set_ctrl #(
        .H_MAX     (H_MAX),
        .TIMEOUT_S (TIMEOUT_S)
    ) u_dut (
        .clk        (clk),
        .clr        (clr),
        .tick       (tick),
        .blink_tick (blink_tick),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .hour       (hour),
        .min        (min),
        .sec        (sec),
        .mode       (mode),
        .blank      (blank),
        .day_pulse  (day_pulse)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_blink = 0, m_to = 0, m_day = 0;
    bit p_mode = 1'b0, p_inc = 1'b0, p_dec = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_blank();
        case (m_mode)
            1: return m_blink << 2;
            2: return m_blink << 1;
            3: return m_blink;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input bit c, input bit t, input bit bt, input bit [2:0] b);
        bit rm, ri, rd, stepped;
        int nm, tot;
        rm = b[0] & ~p_mode;
        ri = b[1] & ~p_inc;
        rd = b[2] & ~p_dec;
        p_mode = b[0]; p_inc = b[1]; p_dec = b[2];
        m_day = 0;
        if (!c) begin
            m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_blink = 0; m_to = 0;
            return;
        end
        stepped = 1'b0;
        nm = m_mode;
        if (m_mode == 0) begin
            m_to = 0;
            if (t) begin
                tot   = (m_h * 3600 + m_m * 60 + m_s + 1) % (H_MAX * 3600);
                m_day = (tot == 0) ? 1 : 0;
                m_h   = tot / 3600;
                m_m   = (tot / 60) % 60;
                m_s   = tot % 60;
            end
            if (rm) nm = 1;
        end else if (rm) begin
            nm = (m_mode + 1) % 4;
            m_to = 0;
        end else if (ri || rd) begin
            m_to = 0;
            if (ri != rd) begin
                stepped = 1'b1;
                if (m_mode == 1) m_h = ri ? (m_h + 1) % H_MAX : (m_h + H_MAX - 1) % H_MAX;
                else if (m_mode == 2) m_m = ri ? (m_m + 1) % 60 : (m_m + 59) % 60;
                else m_s = 0;
            end
        end else if (t) begin
            m_to++;
            if (m_to == TIMEOUT_S) begin
                nm = 0;
                m_to = 0;
            end
        end
        if (nm != m_mode || stepped) m_blink = 0;
        else if (bt && m_mode != 0) m_blink ^= 1;
        m_mode = nm;
    endtask

    task automatic cyc(input bit c, input bit t, input bit bt, input bit [2:0] b);
        @(negedge clk);
        clr = c; tick = t; blink_tick = bt;
        btn_mode = b[0]; btn_inc = b[1]; btn_dec = b[2];
        @(posedge clk);
        model_step(c, t, bt, b);
        #1;
        chk("hour", int'(hour), m_h);
        chk("min", int'(min), m_m);
        chk("sec", int'(sec), m_s);
        chk("mode", int'(mode), m_mode);
        chk("blank", int'(blank), exp_blank());
        chk("day_pulse", int'(day_pulse), m_day);
    endtask

    task automatic press(input bit [2:0] b);
        cyc(1'b1, 1'b0, 1'b0, b);
        cyc(1'b1, 1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [2:0] lvl;
        bit       c, t, bt;

        // reset with btn_mode held; release must not count as an edge
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 3'b001);
        cyc(1'b1, 1'b0, 1'b0, 3'b001);
        chk("held_mode_no_edge", int'(mode), 0);
        cyc(1'b1, 1'b0, 1'b0, 3'b000);

        repeat (61) cyc(1'b1, 1'b1, 1'b0, 3'b000);
        chk("run61_sec", int'(sec), 1);
        chk("run61_min", int'(min), 1);
        chk("run61_hour", int'(hour), 0);

        // SET_H wrap both directions at hour 0
        press(3'b001);
        press(3'b100);
        chk("seth_dec_wrap", int'(hour), 23);
        chk("seth_min_kept", int'(min), 1);
        press(3'b010);
        chk("seth_inc_wrap", int'(hour), 0);
        press(3'b100);

        press(3'b001);
        press(3'b100);
        press(3'b100);
        chk("setm_dec_wrap", int'(min), 59);
        cyc(1'b1, 1'b0, 1'b0, 3'b110);
        chk("setm_inc_dec_same", int'(min), 59);
        cyc(1'b1, 1'b0, 1'b0, 3'b000);
        cyc(1'b1, 1'b0, 1'b0, 3'b011);
        chk("mode_beats_inc_mode", int'(mode), 3);
        chk("mode_beats_inc_min", int'(min), 59);
        cyc(1'b1, 1'b0, 1'b0, 3'b000);
        press(3'b010);
        chk("sets_clear", int'(sec), 0);
        press(3'b001);

        repeat (59) cyc(1'b1, 1'b1, 1'b0, 3'b000);
        chk("preload_sec", int'(sec), 59);
        cyc(1'b1, 1'b1, 1'b0, 3'b000);
        chk("rollover_hour", int'(hour), 0);
        chk("rollover_day", int'(day_pulse), 1);
        cyc(1'b1, 1'b0, 1'b0, 3'b000);
        chk("day_one_cycle", int'(day_pulse), 0);

        press(3'b001);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 3'b000);
            chk("blink_toggle", int'(blank), (i % 2 == 0) ? 4 : 0);
            cyc(1'b1, 1'b0, 1'b0, 3'b000);
        end
        cyc(1'b1, 1'b0, 1'b1, 3'b000);
        cyc(1'b1, 1'b0, 1'b0, 3'b010);
        chk("step_clears_blink", int'(blank), 0);
        cyc(1'b1, 1'b0, 1'b0, 3'b000);

        // SET_M idle timeout from 01:00:00
        press(3'b001);
        repeat (29) cyc(1'b1, 1'b1, 1'b0, 3'b000);
        chk("timeout_not_yet", int'(mode), 2);
        cyc(1'b1, 1'b1, 1'b0, 3'b000);
        chk("timeout_mode", int'(mode), 0);
        chk("timeout_hour", int'(hour), 1);
        chk("timeout_min", int'(min), 0);
        chk("timeout_sec", int'(sec), 0);

        press(3'b001);
        press(3'b010);
        cyc(1'b0, 1'b0, 1'b0, 3'b000);
        chk("reset_midset_mode", int'(mode), 0);
        chk("reset_midset_hour", int'(hour), 0);

        lvl = 3'b000;
        repeat (3000) begin
            c  = ($urandom_range(0, 499) != 0);
            t  = ($urandom_range(0, 5) == 0);
            bt = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 4) == 0) lvl[k] = ~lvl[k];
            cyc(c, t, bt, lvl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
